// File: rtl/serial_disp_pkg.sv
// Shared definitions for the serial display controller.
//   - shift_32 mode encoding ({S1,S0})
//   - controller FSM state encoding
//   - serial word length
package serial_disp_pkg;

  localparam int N_BITS = 32;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SR   = 2'b01;  // shift right, SR enters at bit 31
  localparam logic [1:0] MODE_SL   = 2'b10;  // shift left, SL enters at bit 0
  localparam logic [1:0] MODE_LOAD = 2'b11;  // parallel load from PData

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/serial_disp_ctrl_shift_32.sv
// shift_32: 32-bit universal shift register, the controller's datapath.
// Ports:
//   clk    in  clock, rising edge
//   clear  in  asynchronous active-high clear, Q -> 0
//   S1,S0  in  mode select (hold / shift right / shift left / load)
//   SL     in  bit entering Q[0] on a left shift
//   SR     in  bit entering Q[31] on a right shift
//   PData  in  32-bit parallel load value
//   Q      out 32-bit register contents
module shift_32
  import serial_disp_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        S1,
  input  logic        S0,
  input  logic        SL,
  input  logic        SR,
  input  logic [31:0] PData,
  output logic [31:0] Q
);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      Q <= '0;
    end else begin
      case ({S1, S0})
        MODE_SR:   Q <= {SR, Q[31:1]};
        MODE_SL:   Q <= {Q[30:0], SL};
        MODE_LOAD: Q <= PData;
        default:   Q <= Q;
      endcase
    end
  end

endmodule

// File: rtl/serial_disp_ctrl.sv
// serial_disp_ctrl: transmits a 32-bit word to an external display shift
// chain as sdata/sclk, then pulses rclk to latch it and done to finish.
// Build option: define SERIAL_DISP_LSB_FIRST_EN for LSB-first transmission
// (sdata=Q[0], right shift, SR fill); default is MSB-first with SL fill.
// Ports:
//   clk    in  system clock
//   clear  in  asynchronous active-high reset (also clears shift_32)
//   start  in  transmit request, sampled only while idle
//   pdata  in  word to transmit, captured on the accepting edge
//   busy   out high while a word is in flight (SHIFT/LATCH/DONE)
//   sdata  out serial data bit
//   sclk   out serial clock, chain samples sdata on its rising edge
//   rclk   out one-cycle latch strobe after the last bit
//   done   out one-cycle completion pulse
module serial_disp_ctrl
  import serial_disp_pkg::*;
#(
  parameter int SHIFT_DIV = 2,
  parameter int N_BITS    = serial_disp_pkg::N_BITS
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic [N_BITS-1:0] pdata,
  output logic              busy,
  output logic              sdata,
  output logic              sclk,
  output logic              rclk,
  output logic              done
);

  localparam int DIV_W = (SHIFT_DIV > 2) ? $clog2(SHIFT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SHIFT_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SHIFT_DIV / 2);
  localparam logic [4:0]       LAST_BIT = 5'(N_BITS - 1);

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic [4:0]        bit_cnt;
  logic [1:0]        mode;
  logic [N_BITS-1:0] q;
  logic              fill_sl, fill_sr;
  logic              bit_end;

`ifdef SERIAL_DISP_LSB_FIRST_EN
  localparam logic [1:0] SHIFT_MODE = MODE_SR;
  assign sdata   = q[0];
  assign fill_sl = 1'b0;
  assign fill_sr = 1'b1;
`else
  localparam logic [1:0] SHIFT_MODE = MODE_SL;
  assign sdata   = q[N_BITS-1];
  assign fill_sl = 1'b1;   // blank fill for active-low segments
  assign fill_sr = 1'b0;
`endif

  // Only the output end of Q leaves the register; fold the rest so the
  // remaining bits are visibly consumed.
  logic q_bits_unused;
  assign q_bits_unused = ^q;

  shift_32 u_shift (
    .clk   (clk),
    .clear (clear),
    .S1    (mode[1]),
    .S0    (mode[0]),
    .SL    (fill_sl),
    .SR    (fill_sr),
    .PData (pdata),
    .Q     (q)
  );

  assign busy    = (state != IDLE);
  assign bit_end = (state == SHIFT) && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state != SHIFT) begin
        div_cnt <= '0;
        bit_cnt <= '0;
      end else if (bit_end) begin
        div_cnt <= '0;
        bit_cnt <= bit_cnt + 5'd1;   // wraps 31->0 at end of word
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    mode      = MODE_HOLD;
    sclk      = 1'b0;
    rclk      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          mode      = MODE_LOAD;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // Low half then high half of each bit; Q advances on the edge that
        // ends the high half, so sdata is stable across every sclk rise.
        sclk = (div_cnt >= DIV_HALF);
        if (bit_end) begin
          mode = SHIFT_MODE;
          if (bit_cnt == LAST_BIT) state_nxt = LATCH;
        end
      end
      LATCH: begin
        rclk      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_disp_ctrl.sv
// Bench for serial_disp_ctrl: table of words with expected serial stream,
// latch contents and timing, checked through a scoreboard queue, plus
// hand sequences for ignored start, mid-word clear and back-to-back words.
module tb_serial_disp_ctrl;

  localparam int D  = 2;
  localparam int D4 = 4;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0, start4 = 1'b0;
  logic [31:0] pdata = '0, pdata4 = '0;
  logic        busy, sdata, sclk, rclk, done;
  logic        busy4, sdata4, sclk4, rclk4, done4;

  serial_disp_ctrl #(.SHIFT_DIV(D), .N_BITS(32)) u_dut (
    .clk(clk), .clear(clear), .start(start), .pdata(pdata),
    .busy(busy), .sdata(sdata), .sclk(sclk), .rclk(rclk), .done(done)
  );

  serial_disp_ctrl #(.SHIFT_DIV(D4), .N_BITS(32)) u_dut4 (
    .clk(clk), .clear(clear), .start(start4), .pdata(pdata4),
    .busy(busy4), .sdata(sdata4), .sclk(sclk4), .rclk(rclk4), .done(done4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h, required %h", name, act, req);
    end
  endtask

  typedef struct {
    logic [31:0] word;
    logic [31:0] q_latch;
    int          rclk_cyc;
    int          done_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] pdata;
    exp_t        exp;
  } vec_t;

  exp_t sb[$];
  int   done_cnt = 0;

  // Monitor: rebuilds the serial word from sdata at sclk rises and scores
  // each completed word against the queue.
  initial begin : monitor
    logic [31:0] bits;
    int          nrise, acc_edge, rclk_at;
    logic [31:0] q_at;
    logic        sclk_prev;
    exp_t        e;
    bits = '0; nrise = 0; acc_edge = 0; rclk_at = -1; q_at = '0; sclk_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (clear) begin
        bits = '0; nrise = 0; rclk_at = -1; sclk_prev = 1'b0;
      end else begin
        if (!busy && start) begin
          acc_edge = cyc + 1;
          bits = '0; nrise = 0; rclk_at = -1;
        end
        if (sclk && !sclk_prev) begin
`ifdef SERIAL_DISP_LSB_FIRST_EN
          bits = {sdata, bits[31:1]};
`else
          bits = {bits[30:0], sdata};
`endif
          nrise++;
        end
        sclk_prev = sclk;
        if (rclk) begin
          check("rclk_expected", 32'(sb.size() != 0), 32'd1);
          check("sclk_low_in_latch", 32'(sclk), 32'd0);
          rclk_at = cyc - acc_edge + 1;
          q_at = u_dut.q;
        end
        if (done) begin
          check("done_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("serial_word", bits, e.word);
            check("sclk_rises", 32'(nrise), 32'd32);
            check("rclk_cycle", 32'(rclk_at), 32'(e.rclk_cyc));
            check("done_cycle", 32'(cyc - acc_edge + 1), 32'(e.done_cyc));
            check("q_at_latch", q_at, e.q_latch);
            check("busy_in_done", 32'(busy), 32'd1);
          end
          done_cnt++;
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input bit expect_word, input exp_t e);
    @(posedge clk); #1;
    start = 1'b1;
    pdata = d;
    if (expect_word) sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int target, input int limit);
    int t = 0;
    while (done_cnt < target && t < limit) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("done_within_budget", 32'(done_cnt >= target), 32'd1);
  endtask

  function automatic exp_t mk_exp(input logic [31:0] w);
    exp_t e;
    e.word     = w;
    e.q_latch  = 32'hFFFF_FFFF;
    e.rclk_cyc = 32 * D + 1;
    e.done_cyc = 32 * D + 2;
    return e;
  endfunction

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t        vecs[6];
    logic [31:0] pd_list[6];
    int          target;
    int          dc[3];
    int          n, acc4;
    exp_t        e;

    pd_list = '{32'h8000_0000, 32'hAAAA_AAAA, 32'h0000_0001,
                32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000};
    for (int i = 0; i < 6; i++) begin
      vecs[i].pdata = pd_list[i];
      vecs[i].exp   = mk_exp(pd_list[i]);
    end
    target = 0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_rclk", 32'(rclk), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sdata", 32'(sdata), 32'd0);
    check("rst_q", u_dut.q, 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_sclk", 32'(sclk), 32'd0);

    // table-driven words
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].pdata, 1'b1, vecs[i].exp);
      target++;
      wait_done(target, 32 * D + 20);
    end

    // start while busy is ignored
    send(32'hA5A5_A5A5, 1'b1, mk_exp(32'hA5A5_A5A5));
    repeat (10 * D) @(posedge clk);
    #1;
    start = 1'b1;
    pdata = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0;
    pdata = '0;
    target++;
    wait_done(target, 32 * D + 20);
    repeat (80) @(posedge clk);
    #1;
    check("single_done_after_ignore", 32'(done_cnt), 32'(target));
    check("idle_after_ignore", 32'(busy), 32'd0);

    // clear mid-word aborts it
    send(32'hF0F0_F0F0, 1'b0, e);
    repeat (10 * D) @(posedge clk);
    for (int k = 0; k < D + 1 && !sclk; k++) @(negedge clk);
    check("sclk_high_before_clear", 32'(sclk), 32'd1);
    #1;
    clear = 1'b1;
    #1;
    check("clear_q", u_dut.q, 32'd0);
    check("clear_busy", 32'(busy), 32'd0);
    check("clear_sclk", 32'(sclk), 32'd0);
    check("clear_rclk", 32'(rclk), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("no_done_after_abort", 32'(done_cnt), 32'(target));
    check("idle_after_abort", 32'(busy), 32'd0);
    send(32'h3C3C_3C3C, 1'b1, mk_exp(32'h3C3C_3C3C));
    target++;
    wait_done(target, 32 * D + 20);

    // back-to-back words with start held, SHIFT_DIV=4
    @(posedge clk); #1;
    start4 = 1'b1;
    pdata4 = 32'hC3C3_C3C3;
    acc4   = cyc + 1;
    n = 0;
    dc = '{0, 0, 0};
    for (int t = 0; t < 420; t++) begin
      @(negedge clk);
      if (done4) begin
        if (n < 3) dc[n] = cyc;
        n++;
        if (n == 3) start4 = 1'b0;
      end
    end
    check("b2b_done_count", 32'(n), 32'd3);
    check("b2b_first_latency", 32'(dc[0] - acc4 + 1), 32'(32 * D4 + 2));
    check("b2b_period_1", 32'(dc[1] - dc[0]), 32'(32 * D4 + 3));
    check("b2b_period_2", 32'(dc[2] - dc[1]), 32'(32 * D4 + 3));
    check("b2b_idle_after", 32'(busy4), 32'd0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
